hvac_actuator_driver: RTL
=========================

Name: hvac_actuator_driver

Overview:
- Consumer of the button/comfort controller's outputs (mode, level, heat_cool, ultrasonic_mode).
- Drives the physical actuators:
  - fan PWM whose duty ramps smoothly toward a per-level duty;
  - mutually exclusive heater/compressor enables, with a dead-time interlock on every direction change;
  - humidifier (mist) enable.
- Sits between the control core and the output pins.

Parameters:
- RAMP_DIV, 1000, clk cycles per one-LSB duty step (>=1).
- DEADTIME_CYC, 50000, clk cycles both heat_en/cool_en held low on a direction change or shutdown (>=1).
- DUTY_L0, 64, fan duty for level 0.
- DUTY_L1, 128, fan duty for level 1.
- DUTY_L2, 192, fan duty for level 2.
- DUTY_L3, 255, fan duty for level 3.
- MIST_ON_CYC, 2000, mist burst on-time (feature only).
- MIST_OFF_CYC, 6000, mist burst off-time (feature only).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- mode  in  2  00 IDLE, 01 AUTO, 10 MANUAL, 11 treated as IDLE
- level  in  2  comfort level 0..3
- heat_cool  in  1  0 = heat, 1 = cool
- ultrasonic_mode  in  1  humidifier request
- fan_pwm  out  1  fan PWM
- duty_cur  out  8  current ramped duty
- heat_en  out  1  heater enable
- cool_en  out  1  compressor enable
- mist_en  out  1  humidifier enable
- dir_state  out  2  FSM state: 00 OFF, 01 HEAT, 10 COOL, 11 DEAD

Behaviour:
Reset (synchronous, highest priority in any state):
- fan_pwm=0, duty_cur=0, heat_en=0, cool_en=0, mist_en=0, dir_state=OFF.
- All counters cleared.

PWM:
- 8-bit pwm_cnt increments every clk and wraps 255->0.
- fan_pwm is registered: fan_pwm <= (pwm_cnt < duty_cur).
  - duty 0 gives a constant low.
  - duty 255 gives 255 high cycles per 256.

Ramp:
- duty_tgt = 0 if mode is IDLE/11, else DUTY_L[level].
- tick_cnt counts 0..RAMP_DIV-1; tick asserts on the terminal count.
- On tick: duty_cur moves one step toward duty_tgt (+1 or -1), and holds if equal.
- A target change mid-ramp redirects the ramp at the next tick; no jump.
- No overflow or underflow past 0/255.

Direction FSM:
- OFF: both enables 0.
  - If mode active: go to HEAT (heat_cool=0) or COOL (heat_cool=1) next cycle. No dead time from OFF.
- HEAT: heat_en=1, cool_en=0.
  - If mode inactive or heat_cool=1: go to DEAD, load dt_cnt=DEADTIME_CYC-1.
- COOL: mirror of HEAT.
- DEAD: both enables 0; dt_cnt decrements each clk.
  - At dt_cnt==0, next state is evaluated from the inputs sampled on that cycle: OFF if mode is inactive, else HEAT/COOL per heat_cool.
  - heat_cool toggling during DEAD does not restart the count.
- Enables are registered, decoded from the state.
- heat_en and cool_en are never both 1 in any cycle.
- Minimum gap between opposite enables is DEADTIME_CYC cycles.

Mist:
- mist_en <= ultrasonic_mode & mode-active, registered (1-cycle latency).
- Forced 0 whenever mode is inactive.

Latency:
- Input to enable change: 1 clk, excluding DEAD.

Optional Feature:
HVAC_MIST_BURST_EN:
- Defined: mist_en pulses while ultrasonic_mode is set and mode is active.
  - Starts on, for MIST_ON_CYC cycles, then off for MIST_OFF_CYC cycles, repeating.
  - The burst counter restarts from the on-phase whenever the request rises.
  - The counter clears when the request is removed, and mist_en drops next clk.
- Undefined: plain registered level as in Behaviour; MIST_ON_CYC and MIST_OFF_CYC unused.

Test Plan:
(Common parameters: RAMP_DIV=4, DEADTIME_CYC=20, DUTY_L3=255.)
- Reset, then mode=MANUAL, level=1 -> duty_cur=0 after reset; +1 every 4 clks; holds at 128 after 512 clks; fan_pwm high 128 of each 256 clks once settled.
- At duty 128, level changes 1->0 -> duty_cur decrements by 1 every 4 clks down to 64; never jumps.
- mode=AUTO, heat_cool=0 -> heat_en=1 one clk later.
  - Flip heat_cool to 1: heat_en=0 next clk; both low exactly 20 clks; then cool_en=1.
  - At no point are both enables high.
- In COOL, set mode=IDLE -> DEAD for 20 clks, then OFF; duty_cur ramps to 0; mist_en=0.
- Assert reset mid-DEAD while duty_cur=100 -> all outputs 0 and dir_state=OFF on the next edge; resumes from OFF after release.
- HVAC_MIST_BURST_EN with MIST_ON_CYC=3, MIST_OFF_CYC=5, ultrasonic_mode=1 -> mist_en shows a repeating pattern of 3 high / 5 low; request cleared -> mist_en=0 next clk.

Source files
------------

// File: rtl/hvac_actuator_driver.sv
// Fan PWM with a slow duty ramp, interlocked heater/compressor enables and humidifier drive.
// Define HVAC_MIST_BURST_EN to pulse mist_en in on/off bursts instead of a steady level.
module hvac_actuator_driver #(
  parameter int         RAMP_DIV     = 1000,
  parameter int         DEADTIME_CYC = 50000,
  parameter logic [7:0] DUTY_L0      = 8'd64,
  parameter logic [7:0] DUTY_L1      = 8'd128,
  parameter logic [7:0] DUTY_L2      = 8'd192,
  parameter logic [7:0] DUTY_L3      = 8'd255
`ifdef HVAC_MIST_BURST_EN
  ,
  parameter int         MIST_ON_CYC  = 2000,
  parameter int         MIST_OFF_CYC = 6000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic [1:0] level,
  input  logic       heat_cool,
  input  logic       ultrasonic_mode,
  output logic       fan_pwm,
  output logic [7:0] duty_cur,
  output logic       heat_en,
  output logic       cool_en,
  output logic       mist_en,
  output logic [1:0] dir_state
);

  localparam int TW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DW = (DEADTIME_CYC > 1) ? $clog2(DEADTIME_CYC) : 1;

  typedef enum logic [1:0] {
    DIR_OFF  = 2'b00,
    DIR_HEAT = 2'b01,
    DIR_COOL = 2'b10,
    DIR_DEAD = 2'b11
  } dir_t;

  dir_t          state;
  logic [DW-1:0] dt_cnt;
  logic [TW-1:0] tick_cnt;
  logic [7:0]    pwm_cnt;
  logic [7:0]    duty_tgt;
  logic          mode_active;
  logic          tick;

  assign mode_active = (mode == 2'b01) || (mode == 2'b10);
  assign tick        = (tick_cnt == TW'(RAMP_DIV - 1));
  assign dir_state   = state;

  always_comb begin
    duty_tgt = 8'd0;
    if (mode_active) begin
      case (level)
        2'd0:    duty_tgt = DUTY_L0;
        2'd1:    duty_tgt = DUTY_L1;
        2'd2:    duty_tgt = DUTY_L2;
        default: duty_tgt = DUTY_L3;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= 8'd0;
      fan_pwm <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      fan_pwm <= (pwm_cnt < duty_cur);
    end
  end

  // One LSB per tick, so a target change just redirects the next step.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
      duty_cur <= 8'd0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      if (tick) begin
        if (duty_cur < duty_tgt)
          duty_cur <= duty_cur + 8'd1;
        else if (duty_cur > duty_tgt)
          duty_cur <= duty_cur - 8'd1;
      end
    end
  end

  // Enables are set on entry to each state so they change together with dir_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= DIR_OFF;
      dt_cnt  <= '0;
      heat_en <= 1'b0;
      cool_en <= 1'b0;
    end else begin
      case (state)
        DIR_OFF: begin
          if (mode_active) begin
            state   <= heat_cool ? DIR_COOL : DIR_HEAT;
            heat_en <= !heat_cool;
            cool_en <= heat_cool;
          end
        end
        DIR_HEAT: begin
          if (!mode_active || heat_cool) begin
            state   <= DIR_DEAD;
            dt_cnt  <= DW'(DEADTIME_CYC - 1);
            heat_en <= 1'b0;
          end
        end
        DIR_COOL: begin
          if (!mode_active || !heat_cool) begin
            state   <= DIR_DEAD;
            dt_cnt  <= DW'(DEADTIME_CYC - 1);
            cool_en <= 1'b0;
          end
        end
        DIR_DEAD: begin
          if (dt_cnt == '0) begin
            if (!mode_active) begin
              state <= DIR_OFF;
            end else begin
              state   <= heat_cool ? DIR_COOL : DIR_HEAT;
              heat_en <= !heat_cool;
              cool_en <= heat_cool;
            end
          end else begin
            dt_cnt <= dt_cnt - DW'(1);
          end
        end
        default: state <= DIR_OFF;
      endcase
    end
  end

`ifdef HVAC_MIST_BURST_EN
  localparam int MIST_PERIOD = MIST_ON_CYC + MIST_OFF_CYC;
  localparam int MW = (MIST_PERIOD > 1) ? $clog2(MIST_PERIOD) : 1;

  logic [MW-1:0] mist_cnt;

  // Counter sits at zero while the request is absent, so every new request starts on.
  always_ff @(posedge clk) begin
    if (reset) begin
      mist_cnt <= '0;
      mist_en  <= 1'b0;
    end else if (ultrasonic_mode && mode_active) begin
      mist_en  <= (mist_cnt < MW'(MIST_ON_CYC));
      mist_cnt <= (mist_cnt == MW'(MIST_PERIOD - 1)) ? '0 : mist_cnt + MW'(1);
    end else begin
      mist_cnt <= '0;
      mist_en  <= 1'b0;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset)
      mist_en <= 1'b0;
    else
      mist_en <= ultrasonic_mode && mode_active;
  end
`endif

endmodule
